// File: rtl/srio_ireq_arbiter.sv
// Two-requester SRIO ireq arbiter (round-robin, packet-atomic grants) and a
// TID-based iresp router. Data paths are pure muxes; only control state is registered.
module srio_ireq_arbiter #(
  parameter logic [7:0] C_DB_TID = 8'h55
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        s0_axis_ireq_tvalid,
  output logic        s0_axis_ireq_tready,
  input  logic [63:0] s0_axis_ireq_tdata,
  input  logic        s0_axis_ireq_tlast,

  input  logic        s1_axis_ireq_tvalid,
  output logic        s1_axis_ireq_tready,
  input  logic [63:0] s1_axis_ireq_tdata,
  input  logic        s1_axis_ireq_tlast,

  output logic        m_axis_ireq_tvalid,
  input  logic        m_axis_ireq_tready,
  output logic [63:0] m_axis_ireq_tdata,
  output logic        m_axis_ireq_tlast,

  input  logic        s_axis_iresp_tvalid,
  output logic        s_axis_iresp_tready,
  input  logic [63:0] s_axis_iresp_tdata,
  input  logic [7:0]  s_axis_iresp_tkeep,
  input  logic        s_axis_iresp_tlast,

  output logic        m0_axis_iresp_tvalid,
  input  logic        m0_axis_iresp_tready,
  output logic [63:0] m0_axis_iresp_tdata,
  output logic [7:0]  m0_axis_iresp_tkeep,
  output logic        m0_axis_iresp_tlast,

  output logic        m1_axis_iresp_tvalid,
  input  logic        m1_axis_iresp_tready,
  output logic [63:0] m1_axis_iresp_tdata,
  output logic [7:0]  m1_axis_iresp_tkeep,
  output logic        m1_axis_iresp_tlast
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state_reg;
  logic        last_grant_reg;
  logic [1:0]  gnt_reg;

  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [63:0] req_data [2];
  logic [63:0] data_sel [2];
  logic        ireq_done;

  assign req_valid   = {s1_axis_ireq_tvalid, s0_axis_ireq_tvalid};
  assign req_last    = {s1_axis_ireq_tlast, s0_axis_ireq_tlast};
  assign req_data[0] = s0_axis_ireq_tdata;
  assign req_data[1] = s1_axis_ireq_tdata;

  assign s0_axis_ireq_tready = req_ready[0];
  assign s1_axis_ireq_tready = req_ready[1];

  // gnt_reg is the one-hot decode of state_reg, registered so the muxes see a flop.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready[gi] = gnt_reg[gi] & m_axis_ireq_tready;
      assign data_sel[gi]  = gnt_reg[gi] ? req_data[gi] : 64'h0;
    end
  endgenerate

  assign m_axis_ireq_tvalid = |(gnt_reg & req_valid);
  assign m_axis_ireq_tlast  = |(gnt_reg & req_last);
  assign m_axis_ireq_tdata  = data_sel[0] | data_sel[1];

  assign ireq_done = m_axis_ireq_tvalid & m_axis_ireq_tready & m_axis_ireq_tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      gnt_reg        <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          // On a tie the port that did not win last time is granted.
          if (req_valid[0] && (!req_valid[1] || last_grant_reg)) begin
            state_reg      <= GNT0;
            last_grant_reg <= 1'b0;
            gnt_reg        <= 2'b01;
          end else if (req_valid[1]) begin
            state_reg      <= GNT1;
            last_grant_reg <= 1'b1;
            gnt_reg        <= 2'b10;
          end
        end
        GNT0, GNT1: begin
          if (ireq_done) begin
            state_reg <= IDLE;
            gnt_reg   <= 2'b00;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 2'b00;
        end
      endcase
    end
  end

  logic       resp_busy_reg;
  logic       resp_sel_reg;
  logic       route;
  logic [1:0] resp_hit;
  logic [1:0] resp_ready;
  logic       resp_hs;

  // Mid-packet beats follow the first beat's route; their tdata is payload, not a TID.
  assign route = resp_busy_reg ? resp_sel_reg
                               : (s_axis_iresp_tdata[63:56] != C_DB_TID);

  assign resp_hit   = !aresetn ? 2'b00 : (route ? 2'b10 : 2'b01);
  assign resp_ready = {m1_axis_iresp_tready, m0_axis_iresp_tready};

  assign s_axis_iresp_tready = |(resp_hit & resp_ready);
  assign resp_hs             = s_axis_iresp_tvalid & s_axis_iresp_tready;

  assign m0_axis_iresp_tvalid = resp_hit[0] & s_axis_iresp_tvalid;
  assign m1_axis_iresp_tvalid = resp_hit[1] & s_axis_iresp_tvalid;

  assign m0_axis_iresp_tdata = s_axis_iresp_tdata;
  assign m0_axis_iresp_tkeep = s_axis_iresp_tkeep;
  assign m0_axis_iresp_tlast = s_axis_iresp_tlast;
  assign m1_axis_iresp_tdata = s_axis_iresp_tdata;
  assign m1_axis_iresp_tkeep = s_axis_iresp_tkeep;
  assign m1_axis_iresp_tlast = s_axis_iresp_tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      resp_busy_reg <= 1'b0;
      resp_sel_reg  <= 1'b0;
    end else if (resp_hs) begin
      if (s_axis_iresp_tlast) begin
        resp_busy_reg <= 1'b0;
      end else if (!resp_busy_reg) begin
        resp_busy_reg <= 1'b1;
        resp_sel_reg  <= route;
      end
    end
  end

endmodule

// File: tb/tb_srio_ireq_arbiter.sv
// Self-checking bench for srio_ireq_arbiter: directed scenarios plus a randomized
// run against a packet-level reference model of arbitration and iresp routing.
module tb_srio_ireq_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s0_axis_ireq_tvalid = 0, s0_axis_ireq_tlast = 0;
  logic [63:0] s0_axis_ireq_tdata = 0;
  logic        s0_axis_ireq_tready;
  logic        s1_axis_ireq_tvalid = 0, s1_axis_ireq_tlast = 0;
  logic [63:0] s1_axis_ireq_tdata = 0;
  logic        s1_axis_ireq_tready;
  logic        m_axis_ireq_tvalid, m_axis_ireq_tlast;
  logic [63:0] m_axis_ireq_tdata;
  logic        m_axis_ireq_tready = 0;
  logic        s_axis_iresp_tvalid = 0, s_axis_iresp_tlast = 0;
  logic [63:0] s_axis_iresp_tdata = 0;
  logic [7:0]  s_axis_iresp_tkeep = 0;
  logic        s_axis_iresp_tready;
  logic        m0_axis_iresp_tvalid, m0_axis_iresp_tlast;
  logic [63:0] m0_axis_iresp_tdata;
  logic [7:0]  m0_axis_iresp_tkeep;
  logic        m0_axis_iresp_tready = 0;
  logic        m1_axis_iresp_tvalid, m1_axis_iresp_tlast;
  logic [63:0] m1_axis_iresp_tdata;
  logic [7:0]  m1_axis_iresp_tkeep;
  logic        m1_axis_iresp_tready = 0;

  int checks = 0;
  int errors = 0;

  srio_ireq_arbiter #(.C_DB_TID(8'h55)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axis_ireq_tvalid(s0_axis_ireq_tvalid), .s0_axis_ireq_tready(s0_axis_ireq_tready),
    .s0_axis_ireq_tdata(s0_axis_ireq_tdata), .s0_axis_ireq_tlast(s0_axis_ireq_tlast),
    .s1_axis_ireq_tvalid(s1_axis_ireq_tvalid), .s1_axis_ireq_tready(s1_axis_ireq_tready),
    .s1_axis_ireq_tdata(s1_axis_ireq_tdata), .s1_axis_ireq_tlast(s1_axis_ireq_tlast),
    .m_axis_ireq_tvalid(m_axis_ireq_tvalid), .m_axis_ireq_tready(m_axis_ireq_tready),
    .m_axis_ireq_tdata(m_axis_ireq_tdata), .m_axis_ireq_tlast(m_axis_ireq_tlast),
    .s_axis_iresp_tvalid(s_axis_iresp_tvalid), .s_axis_iresp_tready(s_axis_iresp_tready),
    .s_axis_iresp_tdata(s_axis_iresp_tdata), .s_axis_iresp_tkeep(s_axis_iresp_tkeep),
    .s_axis_iresp_tlast(s_axis_iresp_tlast),
    .m0_axis_iresp_tvalid(m0_axis_iresp_tvalid), .m0_axis_iresp_tready(m0_axis_iresp_tready),
    .m0_axis_iresp_tdata(m0_axis_iresp_tdata), .m0_axis_iresp_tkeep(m0_axis_iresp_tkeep),
    .m0_axis_iresp_tlast(m0_axis_iresp_tlast),
    .m1_axis_iresp_tvalid(m1_axis_iresp_tvalid), .m1_axis_iresp_tready(m1_axis_iresp_tready),
    .m1_axis_iresp_tdata(m1_axis_iresp_tdata), .m1_axis_iresp_tkeep(m1_axis_iresp_tkeep),
    .m1_axis_iresp_tlast(m1_axis_iresp_tlast)
  );

  always #5 aclk = ~aclk;

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs;
    s0_axis_ireq_tvalid = 0; s0_axis_ireq_tlast = 0; s0_axis_ireq_tdata = 0;
    s1_axis_ireq_tvalid = 0; s1_axis_ireq_tlast = 0; s1_axis_ireq_tdata = 0;
    m_axis_ireq_tready = 0;
    s_axis_iresp_tvalid = 0; s_axis_iresp_tlast = 0; s_axis_iresp_tdata = 0; s_axis_iresp_tkeep = 0;
    m0_axis_iresp_tready = 0; m1_axis_iresp_tready = 0;
  endtask

  task automatic test_reset;
    aresetn = 0;
    s0_axis_ireq_tvalid = 1; s0_axis_ireq_tdata = 64'hA5A5; s0_axis_ireq_tlast = 1;
    s1_axis_ireq_tvalid = 1; s1_axis_ireq_tdata = 64'h5A5A; s1_axis_ireq_tlast = 1;
    m_axis_ireq_tready = 1;
    s_axis_iresp_tvalid = 1; s_axis_iresp_tdata = 64'h55D0_0000_0000_0001; s_axis_iresp_tlast = 1;
    m0_axis_iresp_tready = 1; m1_axis_iresp_tready = 1;
    repeat (2) step();
    checks++; if (m_axis_ireq_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %b exp 0", m_axis_ireq_tvalid); end
    checks++; if (m_axis_ireq_tdata !== 64'h0) begin errors++; $display("FAIL rst_m_tdata got %h exp 0", m_axis_ireq_tdata); end
    checks++; if ({s0_axis_ireq_tready, s1_axis_ireq_tready} !== 2'b00) begin errors++; $display("FAIL rst_s_tready got %b exp 00", {s0_axis_ireq_tready, s1_axis_ireq_tready}); end
    checks++; if ({m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, s_axis_iresp_tready} !== 3'b000) begin errors++; $display("FAIL rst_iresp got %b exp 000", {m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, s_axis_iresp_tready}); end
    idle_inputs();
    @(negedge aclk); aresetn = 1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_tie_after_reset;
    s0_axis_ireq_tvalid = 1; s0_axis_ireq_tdata = 64'h0000_0000_0000_AAAA; s0_axis_ireq_tlast = 1;
    s1_axis_ireq_tvalid = 1; s1_axis_ireq_tdata = 64'h0000_0000_0000_BBBB; s1_axis_ireq_tlast = 1;
    m_axis_ireq_tready = 1;
    #1;
    checks++; if (m_axis_ireq_tvalid !== 1'b0) begin errors++; $display("FAIL tie_idle_valid got %b exp 0", m_axis_ireq_tvalid); end
    step();
    checks++; if (m_axis_ireq_tdata !== 64'hAAAA || m_axis_ireq_tvalid !== 1'b1) begin errors++; $display("FAIL tie_first got %h/%b exp aaaa/1", m_axis_ireq_tdata, m_axis_ireq_tvalid); end
    checks++; if ({s0_axis_ireq_tready, s1_axis_ireq_tready} !== 2'b10) begin errors++; $display("FAIL tie_first_ready got %b exp 10", {s0_axis_ireq_tready, s1_axis_ireq_tready}); end
    step();
    s0_axis_ireq_tvalid = 0;
    #1;
    checks++; if (m_axis_ireq_tvalid !== 1'b0 || s1_axis_ireq_tready !== 1'b0) begin errors++; $display("FAIL tie_bubble got %b/%b exp 0/0", m_axis_ireq_tvalid, s1_axis_ireq_tready); end
    step();
    checks++; if (m_axis_ireq_tdata !== 64'hBBBB || s1_axis_ireq_tready !== 1'b1) begin errors++; $display("FAIL tie_second got %h/%b exp bbbb/1", m_axis_ireq_tdata, s1_axis_ireq_tready); end
    step();
    idle_inputs();
    step();
    $display("test_tie_after_reset done");
  endtask

  task automatic test_atomic;
    logic [63:0] beat;
    s1_axis_ireq_tvalid = 1; s1_axis_ireq_tdata = 64'h1000; s1_axis_ireq_tlast = 0;
    m_axis_ireq_tready = 1;
    step();
    for (int b = 0; b < 4; b++) begin
      beat = 64'h1000 + 64'(b);
      s1_axis_ireq_tdata = beat; s1_axis_ireq_tlast = (b == 3);
      if (b >= 1) begin s0_axis_ireq_tvalid = 1; s0_axis_ireq_tdata = 64'hC0C0; s0_axis_ireq_tlast = 1; end
      #1;
      checks++; if (m_axis_ireq_tvalid !== 1'b1 || m_axis_ireq_tdata !== beat) begin errors++; $display("FAIL atomic_beat%0d got %h exp %h", b, m_axis_ireq_tdata, beat); end
      checks++; if ({s0_axis_ireq_tready, s1_axis_ireq_tready} !== 2'b01) begin errors++; $display("FAIL atomic_ready%0d got %b exp 01", b, {s0_axis_ireq_tready, s1_axis_ireq_tready}); end
      step();
    end
    s1_axis_ireq_tvalid = 0;
    #1;
    checks++; if (m_axis_ireq_tvalid !== 1'b0 || s0_axis_ireq_tready !== 1'b0) begin errors++; $display("FAIL atomic_bubble got %b/%b exp 0/0", m_axis_ireq_tvalid, s0_axis_ireq_tready); end
    step();
    checks++; if (m_axis_ireq_tdata !== 64'hC0C0 || s0_axis_ireq_tready !== 1'b1) begin errors++; $display("FAIL atomic_s0_after got %h/%b exp c0c0/1", m_axis_ireq_tdata, s0_axis_ireq_tready); end
    step();
    idle_inputs();
    step();
    $display("test_atomic done");
  endtask

  task automatic test_backpressure;
    logic [63:0] beats [3];
    int ptr = 0;
    int cyc = 0;
    beats[0] = 64'hB0; beats[1] = 64'hB1; beats[2] = 64'hB2;
    s0_axis_ireq_tvalid = 1; s0_axis_ireq_tdata = beats[0]; s0_axis_ireq_tlast = 0;
    step();
    while (ptr < 3 && cyc < 20) begin
      s0_axis_ireq_tdata = beats[ptr]; s0_axis_ireq_tlast = (ptr == 2);
      m_axis_ireq_tready = cyc[0];
      #1;
      checks++; if (m_axis_ireq_tvalid !== 1'b1 || m_axis_ireq_tdata !== beats[ptr]) begin errors++; $display("FAIL bp_beat cyc%0d got %h exp %h", cyc, m_axis_ireq_tdata, beats[ptr]); end
      checks++; if (s0_axis_ireq_tready !== m_axis_ireq_tready) begin errors++; $display("FAIL bp_ready cyc%0d got %b exp %b", cyc, s0_axis_ireq_tready, m_axis_ireq_tready); end
      if (m_axis_ireq_tready) ptr++;
      cyc++;
      step();
    end
    checks++; if (ptr != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", ptr); end
    s0_axis_ireq_tvalid = 0; m_axis_ireq_tready = 1;
    #1;
    checks++; if (m_axis_ireq_tvalid !== 1'b0 || s0_axis_ireq_tready !== 1'b0) begin errors++; $display("FAIL bp_release got %b/%b exp 0/0", m_axis_ireq_tvalid, s0_axis_ireq_tready); end
    idle_inputs();
    step();
    $display("test_backpressure done");
  endtask

  task automatic test_iresp_route;
    logic [63:0] d;
    d = {16'h55D0, 48'(64'($urandom))};
    s_axis_iresp_tvalid = 1; s_axis_iresp_tdata = d; s_axis_iresp_tkeep = 8'hFF; s_axis_iresp_tlast = 1;
    m0_axis_iresp_tready = 1; m1_axis_iresp_tready = 0;
    #1;
    checks++; if ({m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, s_axis_iresp_tready} !== 3'b101) begin errors++; $display("FAIL route_db got %b exp 101", {m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, s_axis_iresp_tready}); end
    checks++; if (m0_axis_iresp_tdata !== d || m1_axis_iresp_tdata !== d || m1_axis_iresp_tkeep !== 8'hFF) begin errors++; $display("FAIL route_fanout got %h/%h exp %h", m0_axis_iresp_tdata, m1_axis_iresp_tdata, d); end
    step();
    d = {8'h12, 56'(64'($urandom))};
    s_axis_iresp_tdata = d; m0_axis_iresp_tready = 1; m1_axis_iresp_tready = 0;
    #1;
    checks++; if ({m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, s_axis_iresp_tready} !== 3'b010) begin errors++; $display("FAIL route_data_stall got %b exp 010", {m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, s_axis_iresp_tready}); end
    m1_axis_iresp_tready = 1;
    #1;
    checks++; if (s_axis_iresp_tready !== 1'b1) begin errors++; $display("FAIL route_data_ready got %b exp 1", s_axis_iresp_tready); end
    step();
    idle_inputs();
    step();
    $display("test_iresp_route done");
  endtask

  task automatic test_iresp_multibeat;
    s_axis_iresp_tvalid = 1; s_axis_iresp_tdata = 64'h1200_0000_0000_0001; s_axis_iresp_tkeep = 8'hFF; s_axis_iresp_tlast = 0;
    m0_axis_iresp_tready = 1; m1_axis_iresp_tready = 0;
    #1;
    checks++; if ({m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, s_axis_iresp_tready} !== 3'b010) begin errors++; $display("FAIL mb_beat0_stall got %b exp 010", {m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, s_axis_iresp_tready}); end
    step();
    m1_axis_iresp_tready = 1;
    #1;
    checks++; if (s_axis_iresp_tready !== 1'b1) begin errors++; $display("FAIL mb_beat0_ready got %b exp 1", s_axis_iresp_tready); end
    step();
    s_axis_iresp_tdata = 64'h5500_0000_0000_0002; s_axis_iresp_tlast = 1; m1_axis_iresp_tready = 0;
    #1;
    checks++; if ({m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, s_axis_iresp_tready} !== 3'b010) begin errors++; $display("FAIL mb_beat1_stall got %b exp 010", {m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, s_axis_iresp_tready}); end
    step();
    m1_axis_iresp_tready = 1;
    #1;
    checks++; if ({m1_axis_iresp_tvalid, s_axis_iresp_tready} !== 2'b11) begin errors++; $display("FAIL mb_beat1_ready got %b exp 11", {m1_axis_iresp_tvalid, s_axis_iresp_tready}); end
    step();
    s_axis_iresp_tdata = 64'h5500_0000_0000_0003; m1_axis_iresp_tready = 0;
    #1;
    checks++; if ({m0_axis_iresp_tvalid, m1_axis_iresp_tvalid} !== 2'b10) begin errors++; $display("FAIL mb_released got %b exp 10", {m0_axis_iresp_tvalid, m1_axis_iresp_tvalid}); end
    step();
    idle_inputs();
    step();
    $display("test_iresp_multibeat done");
  endtask

  task automatic test_reset_mid_packet;
    s1_axis_ireq_tvalid = 1; s1_axis_ireq_tdata = 64'hD0; s1_axis_ireq_tlast = 0;
    m_axis_ireq_tready = 1;
    step();
    checks++; if (m_axis_ireq_tvalid !== 1'b1 || m_axis_ireq_tdata !== 64'hD0) begin errors++; $display("FAIL rmp_granted got %b/%h exp 1/d0", m_axis_ireq_tvalid, m_axis_ireq_tdata); end
    step();
    s1_axis_ireq_tdata = 64'hD1;
    s_axis_iresp_tvalid = 1; s_axis_iresp_tdata = 64'h5500_0000_0000_0000; s_axis_iresp_tlast = 0; m0_axis_iresp_tready = 1;
    #2;
    aresetn = 0;
    #1;
    checks++; if (m_axis_ireq_tvalid !== 1'b0 || s1_axis_ireq_tready !== 1'b0 || m_axis_ireq_tdata !== 64'h0) begin errors++; $display("FAIL rmp_abort got %b/%b/%h exp 0/0/0", m_axis_ireq_tvalid, s1_axis_ireq_tready, m_axis_ireq_tdata); end
    checks++; if ({m0_axis_iresp_tvalid, s_axis_iresp_tready} !== 2'b00) begin errors++; $display("FAIL rmp_iresp got %b exp 00", {m0_axis_iresp_tvalid, s_axis_iresp_tready}); end
    idle_inputs();
    @(negedge aclk); aresetn = 1;
    s0_axis_ireq_tvalid = 1; s0_axis_ireq_tdata = 64'hE0; s0_axis_ireq_tlast = 1;
    s1_axis_ireq_tvalid = 1; s1_axis_ireq_tdata = 64'hE1; s1_axis_ireq_tlast = 1;
    m_axis_ireq_tready = 1;
    #1;
    checks++; if (m_axis_ireq_tvalid !== 1'b0) begin errors++; $display("FAIL rmp_idle got %b exp 0", m_axis_ireq_tvalid); end
    step();
    checks++; if (m_axis_ireq_tdata !== 64'hE0 || {s0_axis_ireq_tready, s1_axis_ireq_tready} !== 2'b10) begin errors++; $display("FAIL rmp_s0_first got %h/%b exp e0/10", m_axis_ireq_tdata, {s0_axis_ireq_tready, s1_axis_ireq_tready}); end
    step();
    s0_axis_ireq_tvalid = 0;
    step();
    checks++; if (m_axis_ireq_tdata !== 64'hE1 || s1_axis_ireq_tready !== 1'b1) begin errors++; $display("FAIL rmp_s1_second got %h/%b exp e1/1", m_axis_ireq_tdata, s1_axis_ireq_tready); end
    step();
    idle_inputs();
    step();
    $display("test_reset_mid_packet done");
  endtask

  // Reference model: packets per source must appear whole and in order; an idle bus
  // hands the next packet to a requester, alternating on contention (port 0 first).
  task automatic test_random;
    logic [63:0] beats [2][160];
    logic        lasts [2][160];
    int          nb [2];
    int          ptr [2];
    logic        v [2];
    logic [63:0] dd [2];
    logic        dl [2];
    int          owner = -1;
    int          prefer = 0;
    int          cyc = 0;
    logic        in_pkt = 0;
    int          dest = 0;
    int          route;
    logic [7:0]  tid;
    logic        rv, rl, m0r, m1r, exp_sready;
    int          npkts = 0;
    for (int k = 0; k < 2; k++) begin
      nb[k] = 0; ptr[k] = 0;
      while (nb[k] < 100) begin
        int len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          beats[k][nb[k]] = {32'(k + 1), 32'($urandom)};
          lasts[k][nb[k]] = (j == len - 1);
          nb[k]++;
        end
      end
    end
    idle_inputs();
    aresetn = 0;
    step();
    @(negedge aclk); aresetn = 1;
    step();
    while ((ptr[0] < nb[0] || ptr[1] < nb[1] || owner >= 0) && cyc < 3000) begin
      for (int k = 0; k < 2; k++) begin
        v[k]  = (ptr[k] < nb[k]) && ($urandom_range(0, 3) != 0);
        dd[k] = (ptr[k] < nb[k]) ? beats[k][ptr[k]] : 64'h0;
        dl[k] = (ptr[k] < nb[k]) ? lasts[k][ptr[k]] : 1'b0;
      end
      s0_axis_ireq_tvalid = v[0]; s0_axis_ireq_tdata = dd[0]; s0_axis_ireq_tlast = dl[0];
      s1_axis_ireq_tvalid = v[1]; s1_axis_ireq_tdata = dd[1]; s1_axis_ireq_tlast = dl[1];
      m_axis_ireq_tready = ($urandom_range(0, 3) != 0);
      tid = ($urandom_range(0, 1) == 1) ? 8'h55 : 8'($urandom);
      rv = 1'($urandom); rl = 1'($urandom); m0r = 1'($urandom); m1r = 1'($urandom);
      s_axis_iresp_tvalid = rv; s_axis_iresp_tdata = {tid, 56'(64'($urandom))};
      s_axis_iresp_tkeep = 8'($urandom); s_axis_iresp_tlast = rl;
      m0_axis_iresp_tready = m0r; m1_axis_iresp_tready = m1r;
      #1;
      checks++; if (m_axis_ireq_tvalid !== (owner >= 0 && v[owner])) begin errors++; $display("FAIL rnd_m_tvalid cyc%0d got %b exp %b", cyc, m_axis_ireq_tvalid, (owner >= 0 && v[owner])); end
      checks++; if (m_axis_ireq_tdata !== ((owner >= 0) ? dd[owner] : 64'h0)) begin errors++; $display("FAIL rnd_m_tdata cyc%0d got %h exp %h", cyc, m_axis_ireq_tdata, (owner >= 0) ? dd[owner] : 64'h0); end
      checks++; if (s0_axis_ireq_tready !== (owner == 0 && m_axis_ireq_tready) || s1_axis_ireq_tready !== (owner == 1 && m_axis_ireq_tready)) begin errors++; $display("FAIL rnd_s_tready cyc%0d got %b%b owner %0d", cyc, s0_axis_ireq_tready, s1_axis_ireq_tready, owner); end
      route = in_pkt ? dest : ((tid == 8'h55) ? 0 : 1);
      exp_sready = (route == 0) ? m0r : m1r;
      checks++; if (m0_axis_iresp_tvalid !== (rv && route == 0) || m1_axis_iresp_tvalid !== (rv && route == 1)) begin errors++; $display("FAIL rnd_iresp_valid cyc%0d got %b%b route %0d", cyc, m0_axis_iresp_tvalid, m1_axis_iresp_tvalid, route); end
      checks++; if (s_axis_iresp_tready !== exp_sready || m1_axis_iresp_tlast !== rl) begin errors++; $display("FAIL rnd_iresp_ready cyc%0d got %b exp %b", cyc, s_axis_iresp_tready, exp_sready); end
      if (owner >= 0) begin
        if (v[owner] && m_axis_ireq_tready) begin
          ptr[owner]++;
          if (dl[owner]) begin owner = -1; npkts++; end
        end
      end else if (v[0] || v[1]) begin
        owner = (v[0] && v[1]) ? prefer : (v[0] ? 0 : 1);
        prefer = 1 - owner;
      end
      if (rv && exp_sready) begin
        if (rl) in_pkt = 0;
        else if (!in_pkt) begin in_pkt = 1; dest = route; end
      end
      cyc++;
      step();
    end
    checks++; if (ptr[0] != nb[0] || ptr[1] != nb[1]) begin errors++; $display("FAIL rnd_drain got %0d/%0d exp %0d/%0d", ptr[0], ptr[1], nb[0], nb[1]); end
    idle_inputs();
    step();
    $display("test_random done: %0d packets over %0d cycles", npkts, cyc);
  endtask

  initial begin
    test_reset();
    test_tie_after_reset();
    test_atomic();
    test_backpressure();
    test_iresp_route();
    test_iresp_multibeat();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule
